// File: rtl/cordic_mul_arbiter.sv
// Round-robin front end for one shared signed multiplier. Each product travels
// down a fixed-length pipeline with its requester tag and is returned only to that requester.
module cordic_mul_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_WIDTH  = 12,
  parameter int MUL_LATENCY = 2
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [DATA_WIDTH-1:0]           mul_din0,
  output logic [DATA_WIDTH-1:0]           mul_din1,
  input  logic [2*DATA_WIDTH-1:0]         mul_dout,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0]         rsp_data,
  output logic                            idle
);

  localparam int TW = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [TW:0] NREQ_W = NUM_REQ[TW:0];

  logic [TW-1:0]         rr_reg;
  logic                  s1_valid_reg;
  logic [TW-1:0]         s1_tag_reg;
  logic [DATA_WIDTH-1:0] s1_a_reg;
  logic [DATA_WIDTH-1:0] s1_b_reg;

  logic                  out_valid;
  logic [TW-1:0]         out_tag;
  logic [PW-1:0]         out_data;
  logic                  tail_busy;
  logic [NUM_REQ-1:0]    out_hit;
  logic                  adv;
  logic                  grant;
  logic [TW-1:0]         win;
  logic                  found;
  logic [TW:0]           idx;

  logic [DATA_WIDTH-1:0] req_a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      assign out_hit[gi]   = out_valid && (out_tag == TW'(gi));
      assign rsp_valid[gi] = out_hit[gi] && !ap_rst;
      assign req_ready[gi] = grant && (win == TW'(gi));
    end
  endgenerate

  // The output stage frees up either when empty or when its owner takes the product.
  assign adv   = !out_valid || |(rsp_ready & out_hit);
  assign grant = adv && |req_valid && !ap_rst;

  // Scan upward from rr with wrap-around; first pending requester wins.
  always_comb begin
    win   = rr_reg;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_reg} + (TW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req_valid[idx[TW-1:0]]) begin
        found = 1'b1;
        win   = idx[TW-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_reg <= '0;
    end else if (grant) begin
      rr_reg <= (win == TW'(NUM_REQ-1)) ? '0 : win + TW'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_reg <= 1'b0;
      s1_tag_reg   <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (adv) begin
      s1_valid_reg <= grant;
      s1_tag_reg   <= win;
      s1_a_reg     <= req_a_arr[win];
      s1_b_reg     <= req_b_arr[win];
    end
  end

  assign mul_din0 = s1_a_reg;
  assign mul_din1 = s1_b_reg;

  generate
    if (MUL_LATENCY == 1) begin : g_lat1
      assign out_valid = s1_valid_reg;
      assign out_tag   = s1_tag_reg;
      assign out_data  = mul_dout;
      assign tail_busy = 1'b0;
    end else begin : g_latn
      // Index k here is pipeline stage k+1; the highest index is the output stage.
      logic [MUL_LATENCY-1:1] pv_reg;
      logic [TW-1:0]          pt_reg [1:MUL_LATENCY-1];
      logic [PW-1:0]          pp_reg [1:MUL_LATENCY-1];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int k = 1; k < MUL_LATENCY; k++) begin
            pv_reg[k] <= 1'b0;
            pt_reg[k] <= '0;
            pp_reg[k] <= '0;
          end
        end else if (adv) begin
          pv_reg[1] <= s1_valid_reg;
          pt_reg[1] <= s1_tag_reg;
          pp_reg[1] <= mul_dout;
          for (int k = 2; k < MUL_LATENCY; k++) begin
            pv_reg[k] <= pv_reg[k-1];
            pt_reg[k] <= pt_reg[k-1];
            pp_reg[k] <= pp_reg[k-1];
          end
        end
      end

      assign out_valid = pv_reg[MUL_LATENCY-1];
      assign out_tag   = pt_reg[MUL_LATENCY-1];
      assign out_data  = pp_reg[MUL_LATENCY-1];
      assign tail_busy = |pv_reg;
    end
  endgenerate

  assign rsp_data = out_data;
  assign idle     = ap_rst || !(s1_valid_reg || tail_busy);

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// Directed bench: a 3-requester, latency-2 arbiter and a latency-1 build,
// each with a behavioural multiplier on the mul_din/mul_dout ports.
module tb_cordic_mul_arbiter;

  logic        clk;
  logic        ap_rst;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [35:0] req_a, req_b;
  logic [11:0] mul_din0, mul_din1;
  logic [23:0] mul_dout, rsp_data;
  logic        idle;

  logic [2:0]  x_req_valid, x_req_ready, x_rsp_valid, x_rsp_ready;
  logic [35:0] x_req_a, x_req_b;
  logic [11:0] x_mul_din0, x_mul_din1;
  logic [23:0] x_mul_dout, x_rsp_data;
  logic        x_idle;

  int checks = 0;
  int failures = 0;
  logic [23:0] fexp [0:8];
  logic [11:0] fa [0:2];
  logic [11:0] fb [0:2];

  function automatic logic [23:0] mul24(input logic [11:0] a, input logic [11:0] b);
    logic signed [23:0] ea, eb;
    ea = {{12{a[11]}}, a};
    eb = {{12{b[11]}}, b};
    return ea * eb;
  endfunction

  assign mul_dout   = mul24(mul_din0, mul_din1);
  assign x_mul_dout = mul24(x_mul_din0, x_mul_din1);

  cordic_mul_arbiter #(.NUM_REQ(3), .DATA_WIDTH(12), .MUL_LATENCY(2)) u_dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .idle(idle)
  );

  cordic_mul_arbiter #(.NUM_REQ(3), .DATA_WIDTH(12), .MUL_LATENCY(1)) u_dut1 (
    .ap_clk(clk), .ap_rst(ap_rst),
    .req_valid(x_req_valid), .req_ready(x_req_ready), .req_a(x_req_a), .req_b(x_req_b),
    .mul_din0(x_mul_din0), .mul_din1(x_mul_din1), .mul_dout(x_mul_dout),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data), .idle(x_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!ap_rst && |(rsp_valid & rsp_ready))
      $display("rsp valid=%b data=%06h", rsp_valid, rsp_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    req_a[i*12 +: 12] = a;
    req_b[i*12 +: 12] = b;
  endtask

  initial begin
    ap_rst = 1'b1;
    req_valid = 3'b111; req_a = '0; req_b = '0; rsp_ready = 3'b111;
    x_req_valid = 3'b000; x_req_a = '0; x_req_b = '0; x_rsp_ready = 3'b111;

    // reset state
    @(posedge clk); @(posedge clk); #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_din0", 32'(mul_din0), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    ap_rst = 1'b0; req_valid = 3'b000;
    tick();

    // single request: 3 * -5
    set_op(0, 12'd3, 12'hFFB); req_valid = 3'b001; #1;
    check("single_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = 3'b000; #1;
    check("single_busy", 32'(idle), 32'h0);
    check("single_din0", 32'(mul_din0), 32'h003);
    check("single_din1", 32'(mul_din1), 32'hFFB);
    check("single_early", 32'(rsp_valid), 32'h0);
    tick(); #1;
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data", 32'(rsp_data), 32'hFFFFF1);
    tick(); #1;
    check("single_idle", 32'(idle), 32'h1);
    check("single_done", 32'(rsp_valid), 32'h0);

    // corner products from requester 2
    set_op(2, 12'h800, 12'h800); req_valid = 3'b100; #1;
    check("corner_grant0", 32'(req_ready), 32'h4);
    tick(); set_op(2, 12'h7FF, 12'h800); #1;
    check("corner_grant1", 32'(req_ready), 32'h4);
    tick(); req_valid = 3'b000; #1;
    check("corner_valid0", 32'(rsp_valid), 32'h4);
    check("corner_data0", 32'(rsp_data), 32'h400000);
    tick(); #1;
    check("corner_valid1", 32'(rsp_valid), 32'h4);
    check("corner_data1", 32'(rsp_data), 32'hC00800);
    tick();

    // fairness: all three requesters continuously valid for 9 cycles
    for (int j = 0; j < 11; j++) begin
      if (j < 9) begin
        for (int i = 0; i < 3; i++) begin
          fa[i] = 12'(j*8 + i + 1);
          fb[i] = 12'(-(i + 2));
          set_op(i, fa[i], fb[i]);
        end
        fexp[j] = mul24(fa[j%3], fb[j%3]);
        req_valid = 3'b111;
      end else begin
        req_valid = 3'b000;
      end
      #1;
      if (j < 9) check("fair_grant", 32'(req_ready), 32'(1 << (j % 3)));
      if (j >= 2) begin
        check("fair_valid", 32'(rsp_valid), 32'(1 << ((j-2) % 3)));
        check("fair_data", 32'(rsp_data), 32'(fexp[j-2]));
      end
      tick();
    end

    // backpressure on requester 1 with 0 and 2 pending
    set_op(1, 12'd100, 12'hFFD); rsp_ready = 3'b101; req_valid = 3'b010; #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    tick(); req_valid = 3'b000;
    tick();
    set_op(0, 12'd7, 12'd9); set_op(2, 12'd5, 12'hFFF); req_valid = 3'b101;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("bp_hold_ready", 32'(req_ready), 32'h0);
      check("bp_hold_valid", 32'(rsp_valid), 32'h2);
      check("bp_hold_data", 32'(rsp_data), 32'hFFFED4);
      tick();
    end
    rsp_ready = 3'b111; #1;
    check("bp_rel_valid", 32'(rsp_valid), 32'h2);
    check("bp_rel_data", 32'(rsp_data), 32'hFFFED4);
    check("bp_rel_grant2", 32'(req_ready), 32'h4);
    tick(); req_valid = 3'b001; #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    check("bp_bubble", 32'(rsp_valid), 32'h0);
    tick(); req_valid = 3'b000; #1;
    check("bp_valid2", 32'(rsp_valid), 32'h4);
    check("bp_data2", 32'(rsp_data), 32'hFFFFFB);
    tick(); #1;
    check("bp_valid0", 32'(rsp_valid), 32'h1);
    check("bp_data0", 32'(rsp_data), 32'h00003F);
    tick(); #1;
    check("bp_idle", 32'(idle), 32'h1);
    check("bp_done", 32'(rsp_valid), 32'h0);

    // reset with two products in flight
    set_op(0, 12'd1, 12'd1); req_valid = 3'b001; #1;
    check("mr_grant0", 32'(req_ready), 32'h1);
    tick(); set_op(1, 12'd2, 12'd2); req_valid = 3'b010; #1;
    check("mr_grant1", 32'(req_ready), 32'h2);
    tick(); req_valid = 3'b110; ap_rst = 1'b1; #1;
    check("mr_rst_ready", 32'(req_ready), 32'h0);
    check("mr_rst_valid", 32'(rsp_valid), 32'h0);
    check("mr_rst_idle", 32'(idle), 32'h1);
    tick(); ap_rst = 1'b0;
    set_op(1, 12'hFFF, 12'hFFF); set_op(2, 12'd2, 12'hFFD); #1;
    check("mr_grant_first", 32'(req_ready), 32'h2);
    check("mr_no_rsp", 32'(rsp_valid), 32'h0);
    check("mr_idle", 32'(idle), 32'h1);
    check("mr_din0", 32'(mul_din0), 32'h0);
    tick(); req_valid = 3'b100; #1;
    check("mr_grant_second", 32'(req_ready), 32'h4);
    check("mr_no_rsp2", 32'(rsp_valid), 32'h0);
    tick(); req_valid = 3'b000; #1;
    check("mr_valid1", 32'(rsp_valid), 32'h2);
    check("mr_data1", 32'(rsp_data), 32'h000001);
    tick(); #1;
    check("mr_valid2", 32'(rsp_valid), 32'h4);
    check("mr_data2", 32'(rsp_data), 32'hFFFFFA);
    tick(); #1;
    check("mr_idle_end", 32'(idle), 32'h1);

    // latency-1 build, single request
    x_req_a[11:0] = 12'd3; x_req_b[11:0] = 12'hFFB; x_req_valid = 3'b001; #1;
    check("l1_grant", 32'(x_req_ready), 32'h1);
    tick(); x_req_valid = 3'b000; #1;
    check("l1_valid", 32'(x_rsp_valid), 32'h1);
    check("l1_data", 32'(x_rsp_data), 32'hFFFFF1);
    check("l1_busy", 32'(x_idle), 32'h0);
    tick(); #1;
    check("l1_done", 32'(x_rsp_valid), 32'h0);
    check("l1_idle", 32'(x_idle), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
